// File: rtl/sram_ctrl_if.sv
// Request/response bus between a client and the asynchronous-SRAM controller.
// The master issues word requests; the slave returns read data and readiness.
interface sram_ctrl_if #(
  parameter int ADDR_W = 18
) ();
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic [1:0]        req_be;
  logic              req_ready;
  logic              rd_valid;
  logic [15:0]       rd_data;
  logic              init_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rd_valid, rd_data, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rd_valid, rd_data, init_done
  );
endinterface

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller with fixed-length read/write strobes.
// Define SRAM_CTRL_CLEAR_EN to zero the whole array after every reset release.
module sram_ctrl #(
  parameter int ADDR_W        = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] ADR,
  output logic [15:0]       dat_out,
  output logic              dat_oe,
  input  logic [15:0]       dat_in,
  output logic              RAMCS,
  output logic              RAMOE,
  output logic              RAMWE,
  output logic              RAMLB,
  output logic              RAMUB
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WR_REC
`ifdef SRAM_CTRL_CLEAR_EN
    , ST_CLEAR
`endif
  } state_t;

`ifdef SRAM_CTRL_CLEAR_EN
  localparam state_t ST_RESET = ST_CLEAR;
`else
  localparam state_t ST_RESET = ST_IDLE;
`endif

  // Strobe counter runs ACCESS_CYCLES-1 down to 0; the access ends on the zero cycle.
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [1:0]  be_q;
  logic        rd_valid_q;
  logic [15:0] rd_data_q;
  logic        init_done_q;
  logic        accept;
  logic        cnt_zero;

  assign bus.req_ready = (state == ST_IDLE) && init_done_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.init_done = init_done_q;
  assign accept        = bus.req_valid && bus.req_ready;
  assign cnt_zero      = (cnt == 4'd0);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RESET;
    else      state <= state_nxt;
  end

  // Strobes decode straight from state, so an asynchronous reset releases them at once.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nxt = state;
    RAMCS     = 1'b1;
    RAMOE     = 1'b1;
    RAMWE     = 1'b1;
    RAMLB     = 1'b1;
    RAMUB     = 1'b1;
    dat_oe    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = bus.req_write ? ST_WR : ST_RD;
      end
      ST_RD: begin
        RAMCS = 1'b0;
        RAMOE = 1'b0;
        RAMLB = 1'b0;
        RAMUB = 1'b0;
        if (cnt_zero) state_nxt = ST_IDLE;
      end
      ST_WR: begin
        RAMCS  = 1'b0;
        RAMWE  = 1'b0;
        dat_oe = 1'b1;
        RAMLB  = ~be_q[0];
        RAMUB  = ~be_q[1];
        if (cnt_zero) state_nxt = ST_WR_REC;
      end
      ST_WR_REC: begin
        dat_oe = 1'b1;
        RAMLB  = ~be_q[0];
        RAMUB  = ~be_q[1];
`ifdef SRAM_CTRL_CLEAR_EN
        // Until init_done the recovery cycle chains straight into the next clear write.
        state_nxt = (!init_done_q && !(&ADR)) ? ST_WR : ST_IDLE;
`else
        state_nxt = ST_IDLE;
`endif
      end
`ifdef SRAM_CTRL_CLEAR_EN
      ST_CLEAR: state_nxt = ST_WR;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ADR         <= '0;
      dat_out     <= '0;
      be_q        <= '0;
      cnt         <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
`ifndef SRAM_CTRL_CLEAR_EN
      init_done_q <= 1'b1;
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ADR     <= bus.req_addr;
            dat_out <= bus.req_wdata;
            be_q    <= bus.req_be;
            cnt     <= CNT_LOAD;
          end
        end
        ST_RD: begin
          if (cnt_zero) begin
            rd_data_q  <= dat_in;
            rd_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WR: begin
          if (!cnt_zero) cnt <= cnt - 4'd1;
        end
`ifdef SRAM_CTRL_CLEAR_EN
        ST_WR_REC: begin
          if (!init_done_q) begin
            if (&ADR) begin
              init_done_q <= 1'b1;
            end else begin
              ADR <= ADR + 1'b1;
              cnt <= CNT_LOAD;
            end
          end
        end
        ST_CLEAR: begin
          ADR     <= '0;
          dat_out <= '0;
          be_q    <= 2'b11;
          cnt     <= CNT_LOAD;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomised scoreboard bench for sram_ctrl: word-level memory model predicts read
// data, a monitor checks strobe timing, latency and back-to-back spacing.
module tb_sram_ctrl;
  localparam int AW    = 6;
  localparam int AC    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef SRAM_CTRL_CLEAR_EN
  localparam int INIT_CYC = DEPTH * (AC + 1) + 1;
`else
  localparam int INIT_CYC = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_W(AW)) bus ();

  logic [AW-1:0] ADR;
  logic [15:0]   dat_out, dat_in;
  logic          dat_oe, RAMCS, RAMOE, RAMWE, RAMLB, RAMUB;

  sram_ctrl #(.ADDR_W(AW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ADR(ADR), .dat_out(dat_out), .dat_oe(dat_oe), .dat_in(dat_in),
    .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMWE(RAMWE), .RAMLB(RAMLB), .RAMUB(RAMUB)
  );

  function automatic logic [15:0] init_word(input int i);
`ifdef SRAM_CTRL_CLEAR_EN
    init_word = 16'hFFFF;
`else
    init_word = 16'(i * 16'h1357) ^ 16'hA5C3;
`endif
  endfunction

  // SRAM device: drives data while selected and output-enabled, stores byte lanes under RAMWE.
  logic [15:0] sram [DEPTH];
  logic        preload_done = 1'b0;
  assign dat_in = (!RAMCS && !RAMOE) ? sram[ADR] : 16'h0000;
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
      preload_done <= 1'b1;
    end else if (rst && !RAMCS && !RAMWE) begin
      if (!RAMLB) sram[ADR][7:0]  <= dat_out[7:0];
      if (!RAMUB) sram[ADR][15:8] <= dat_out[15:8];
    end
  end

  // Reference memory and scoreboard.
  typedef struct { logic [15:0] data; int acc; } exp_t;
  logic [15:0] ref_mem [DEPTH];
  exp_t        sb [$];
  exp_t        e;
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          prev_acc;
  bit          prev_w;
  bit          have_prev = 1'b0;
  int          we_run = 0;
  int          oe_run = 0;
  logic [15:0] prev_rd = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit w, input logic [AW-1:0] a, input logic [15:0] d,
                      input logic [1:0] be, input bit b2b);
    int n;
    int acc;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'(n), 32'd0);
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (b2b && have_prev)
      check("b2b_interval", 32'(acc - prev_acc), prev_w ? 32'(AC + 2) : 32'(AC + 1));
    have_prev = 1'b1;
    prev_acc  = acc;
    prev_w    = w;
    if (w) begin
      if (be[0]) ref_mem[a][7:0]  = d[7:0];
      if (be[1]) ref_mem[a][15:8] = d[15:8];
    end else begin
      sb.push_back('{data: ref_mem[a], acc: acc});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    have_prev     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.req_valid = 1'b0;
    have_prev     = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (AC + 3) @(negedge clk);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.init_done && n < 1000);
    check("init_done_cycles", 32'(n), 32'(INIT_CYC));
  endtask

  // Monitor: pops the scoreboard on rd_valid and checks strobe rules every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      we_run  = 0;
      oe_run  = 0;
      prev_rd = 16'h0000;
    end else begin
      check("strobe_overlap", {30'd0, ~RAMWE & ~RAMOE, dat_oe & ~RAMOE}, 32'd0);
      if (bus.rd_valid) begin
        if (sb.size() == 0) begin
          check("spurious_rd_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rd_data", {16'd0, bus.rd_data}, {16'd0, e.data});
          check("rd_latency", 32'(cyc - e.acc), 32'(AC));
          prev_rd = e.data;
        end
      end else begin
        check("rd_data_hold", {16'd0, bus.rd_data}, {16'd0, prev_rd});
      end
      if (!RAMWE) begin
        we_run++;
        check("wr_strobe", {30'd0, RAMCS, dat_oe}, 32'b01);
      end else begin
        if (we_run != 0) begin
          check("we_low_cycles", 32'(we_run), 32'(AC));
          check("wr_recovery", {29'd0, RAMCS, dat_oe, RAMOE}, 32'b111);
        end
        we_run = 0;
      end
      if (!RAMOE) begin
        oe_run++;
      end else begin
        if (oe_run != 0) check("oe_low_cycles", 32'(oe_run), 32'(AC));
        oe_run = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (vectors=%0d)", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SRAM_CTRL_CLEAR_EN
      ref_mem[i] = 16'h0000;
`else
      ref_mem[i] = init_word(i);
`endif
    end

    repeat (3) @(negedge clk);
    check("reset_strobes_flags",
          {23'd0, RAMCS, RAMOE, RAMWE, RAMLB, RAMUB, dat_oe, bus.rd_valid, bus.init_done, bus.req_ready},
          32'b111110000);
    check("reset_adr", 32'(ADR), 32'd0);
    check("reset_dat_out", {16'd0, dat_out}, 32'd0);
    check("reset_rd_data", {16'd0, bus.rd_data}, 32'd0);
    rst = 1'b1;
    wait_init();

    // Directed: full write, read-back, partial-byte write, zero-enable write.
    send(1'b1, AW'(5), 16'hBEEF, 2'b11, 1'b0);
    send(1'b0, AW'(5), 16'h0000, 2'b00, 1'b1);
    send(1'b1, AW'(5), 16'h1234, 2'b01, 1'b1);
    send(1'b0, AW'(5), 16'h0000, 2'b00, 1'b1);
    send(1'b1, AW'(5), 16'hFFFF, 2'b00, 1'b1);
    send(1'b0, AW'(5), 16'h0000, 2'b00, 1'b1);
    drain();

    // Back-to-back alternating reads and writes with valid held high.
    for (int i = 0; i < 40; i++)
      send(i[0], AW'($urandom_range(0, DEPTH - 1)), 16'($urandom),
           2'($urandom_range(0, 3)), 1'b1);
    drain();

    // Random mix with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), 16'($urandom),
           2'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      else have_prev = 1'b0;
    end
    drain();

    // Reset in the first RD cycle aborts the read without a rd_valid pulse.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = AW'(5);
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_strobes", {26'd0, RAMCS, RAMOE, RAMWE, RAMLB, RAMUB, dat_oe}, 32'b111110);
    check("abort_flags", {29'd0, bus.rd_valid, bus.init_done, bus.req_ready}, 32'd0);
    repeat (3) @(negedge clk);
`ifdef SRAM_CTRL_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
`endif
    rst = 1'b1;
    wait_init();

    for (int i = 0; i < 30; i++)
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), 16'($urandom),
           2'($urandom_range(0, 3)), 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
